// File: rtl/cpu_control_sequencer.sv
// Multi-cycle fetch/decode/execute controller for the 20-bit {opcode, operand} instruction format.
// Build option: define ILLEGAL_OP_TRAP_EN to trap opcodes 7-E into HALT and raise sticky illegal_op.
//
// state  | meaning
// IDLE   | waiting for run
// FETCH  | instruction read at pc, holds until mem_ack
// DECODE | opcode valid in IR, selects next state
// EXEC   | one-cycle ALU / jump action
// MEM    | LOAD/STORE data access, holds until mem_ack
// HALT   | stopped until reset
module cpu_control_sequencer #(
   parameter int unsigned       ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   input  logic [3:0]        ir_opcode,
   input  logic [15:0]       ir_operand,
   input  logic              acc_zero,
   input  logic              mem_ack,
   output logic              ir_load,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [ADDR_W-1:0] pc,
   output logic              acc_load,
   output logic [1:0]        alu_op,
   output logic              halted,
   output logic              illegal_op,
   output logic [2:0]        state
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   localparam logic [3:0] OP_LOAD  = 4'h1;
   localparam logic [3:0] OP_STORE = 4'h2;
   localparam logic [3:0] OP_ADDI  = 4'h3;
   localparam logic [3:0] OP_SUBI  = 4'h4;
   localparam logic [3:0] OP_JMP   = 4'h5;
   localparam logic [3:0] OP_JZ    = 4'h6;
   localparam logic [3:0] OP_HALT  = 4'hF;

   state_t            state_q, state_d, boundary_state;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              halted_q, halted_d;
   logic [ADDR_W-1:0] operand_addr;
`ifdef ILLEGAL_OP_TRAP_EN
   logic              illegal_q, illegal_d, trap;
`endif

   assign operand_addr   = ir_operand[ADDR_W-1:0];
   assign boundary_state = run ? S_FETCH : S_IDLE;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      mem_addr_d = mem_addr_q;
      ir_load    = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      acc_load   = 1'b0;
      alu_op     = 2'b00;
`ifdef ILLEGAL_OP_TRAP_EN
      trap       = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (run) state_d = S_FETCH;
         end
         S_FETCH: begin
            mem_req    = 1'b1;
            mem_addr_d = pc_q;
            if (mem_ack) begin
               ir_load = 1'b1;
               pc_d    = pc_q + ADDR_W'(1);
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            case (ir_opcode)
               OP_LOAD, OP_STORE: state_d = S_MEM;
               OP_HALT:           state_d = S_HALT;
               default: begin
                  state_d = S_EXEC;
`ifdef ILLEGAL_OP_TRAP_EN
                  if (ir_opcode >= 4'h7) begin
                     trap    = 1'b1;
                     state_d = S_HALT;
                  end
`endif
               end
            endcase
         end
         S_EXEC: begin
            state_d = boundary_state;
            case (ir_opcode)
               OP_ADDI: begin
                  acc_load = 1'b1;
                  alu_op   = 2'b01;
               end
               OP_SUBI: begin
                  acc_load = 1'b1;
                  alu_op   = 2'b10;
               end
               OP_JMP:  pc_d = operand_addr;
               OP_JZ:   if (acc_zero) pc_d = operand_addr;
               default: ;
            endcase
         end
         S_MEM: begin
            mem_req    = 1'b1;
            mem_we     = (ir_opcode == OP_STORE);
            mem_addr_d = operand_addr;
            if (mem_ack) begin
               acc_load = (ir_opcode == OP_LOAD);
               state_d  = boundary_state;
            end
         end
         S_HALT:  ;
         default: state_d = S_IDLE;
      endcase
      halted_d = halted_q | (state_d == S_HALT);
`ifdef ILLEGAL_OP_TRAP_EN
      illegal_d = illegal_q | trap;
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_PC;
         mem_addr_q <= '0;
         halted_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         mem_addr_q <= mem_addr_d;
         halted_q   <= halted_d;
      end
   end

`ifdef ILLEGAL_OP_TRAP_EN
   always_ff @(posedge clk) begin
      if (!rst_n) illegal_q <= 1'b0;
      else        illegal_q <= illegal_d;
   end
   assign illegal_op = illegal_q;
`else
   assign illegal_op = 1'b0;
`endif

   // mem_addr follows the live request address and otherwise holds the last one issued
   assign mem_addr = mem_addr_d;
   assign pc       = pc_q;
   assign halted   = halted_q;
   assign state    = state_q;

endmodule

// File: doc/cpu_control_sequencer.md
Name: cpu_control_sequencer

Overview:
- Multi-cycle fetch/decode/execute controller for the 20-bit instruction format: opcode in [19:16], operand in [15:0].
- Owns the program counter and drives the single-port memory handshake.
- Qualifies capture into the instruction register and issues accumulator/ALU control.
- Sits between instruction memory/data memory, the instruction register and the accumulator datapath.

Parameters:
- ADDR_W, 16, width of pc and mem_addr; operand[ADDR_W-1:0] is used as the address.
- RESET_PC, 0, pc value after reset.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- run  in  1  level enable; starts execution from IDLE and is sampled at instruction boundaries
- ir_opcode  in  4  opcode from the instruction register
- ir_operand  in  16  operand from the instruction register
- acc_zero  in  1  accumulator == 0 flag
- mem_ack  in  1  memory completes the current request this cycle
- ir_load  out  1  instruction register capture qualifier
- mem_req  out  1  memory request
- mem_we  out  1  1 = write (STORE), 0 = read
- mem_addr  out  ADDR_W  memory address
- pc  out  ADDR_W  program counter
- acc_load  out  1  accumulator load strobe
- alu_op  out  2  00 PASS, 01 ADD, 10 SUB
- halted  out  1  sticky halt status
- illegal_op  out  1  sticky illegal-opcode flag
- state  out  3  current state: IDLE 0, FETCH 1, DECODE 2, EXEC 3, MEM 4, HALT 5

Behaviour:
- Reset: rst_n low at a clk edge puts the block in IDLE.
  - pc = RESET_PC.
  - halted = 0, illegal_op = 0.
  - All strobes are 0; mem_addr = 0; alu_op = 00.
  - Reset overrides any state, including mid-MEM and HALT. A pending memory request is abandoned with no further strobes.
- Opcode map:
  - 0 NOP, 1 LOAD, 2 STORE, 3 ADDI, 4 SUBI, 5 JMP, 6 JZ, F HALT.
  - 7–E are undefined.
- IDLE: all strobes low. run = 1 moves to FETCH next cycle.
- FETCH:
  - mem_req = 1, mem_we = 0, mem_addr = pc.
  - Holds until mem_ack.
  - In the mem_ack cycle, ir_load = 1 (combinational on mem_ack), pc <= pc + 1 (modulo 2^ADDR_W), and the next state is DECODE.
- DECODE: one cycle, opcode is valid. Next state:
  - LOAD/STORE: MEM.
  - F: HALT.
  - All others: EXEC.
- EXEC: one cycle.
  - ADDI/SUBI: acc_load = 1, alu_op = 01/10; the ALU uses ir_operand.
  - JMP: pc <= ir_operand[ADDR_W-1:0].
  - JZ: if acc_zero, same as JMP; otherwise pc is unchanged.
  - NOP: no action.
- MEM:
  - mem_req = 1, mem_addr = ir_operand[ADDR_W-1:0], mem_we = 1 for STORE.
  - Holds until mem_ack.
  - LOAD: acc_load = 1 with alu_op = 00 in the ack cycle.
- Instruction boundary (leaving EXEC, or MEM on ack): go to FETCH if run = 1, else IDLE. run is ignored mid-instruction.
- HALT: halted = 1. The block stays in HALT until reset; run has no effect.
- Outputs in the default case: mem_req, mem_we, acc_load and ir_load are 0 in every state not listed above. mem_addr holds its last value when mem_req = 0.
- Signal handling:
  - mem_ack while mem_req = 0 is ignored.
  - mem_ack asserted in the same cycle the request is first raised is a legal zero-wait completion.
- Latency with zero-wait ack: 3 cycles per instruction (FETCH, DECODE, EXEC/MEM). Each memory wait cycle adds 1.
- pc wrap: 2^ADDR_W−1 + 1 = 0, no flag.

Optional Feature:
- Macro: ILLEGAL_OP_TRAP_EN.
- Defined: opcodes 7–E in DECODE set illegal_op = 1 (sticky), and the next state is HALT, so halted = 1.
- Undefined: opcodes 7–E execute as NOP through EXEC, and illegal_op is tied 0.

Test Plan:
- Reset then run = 1; memory returns NOP with zero-wait ack -> state 0→1→2→3→1; pc 0→1; ir_load pulses once in the FETCH ack cycle; 3 cycles per instruction.
- FETCH with mem_ack delayed 4 cycles -> mem_req held high with mem_addr = pc throughout; pc increments only in the ack cycle.
- Program: ADDI 5, LOAD 0x0010 (ack after 2 waits), STORE 0x0020, JZ 0x0000 with acc_zero = 0 -> acc_load with alu_op 01 then 00; the STORE cycle shows mem_we = 1, mem_addr = 0x0020; after JZ, pc = 4.
- JMP 0xFFFF, then NOP at 0xFFFF -> pc = 0xFFFF, then wraps to 0x0000 after that fetch.
- run dropped during a MEM wait -> the instruction completes, then IDLE with pc held. rst_n low for one cycle mid-FETCH -> IDLE, pc = RESET_PC, mem_req = 0 the next cycle.
- Fetch opcode 0x9 -> with ILLEGAL_OP_TRAP_EN: HALT, illegal_op = 1, halted = 1, run ignored. Without it: NOP behaviour, pc advances.
